// File: rtl/mem_port_credit_buffer.sv
// Credit-gated request front-end for one memory island port. Requests are only
// issued when a response slot is reserved, so unstoppable island responses always fit.
module mem_port_credit_buffer #(
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 64,
   parameter int StrbWidth      = DataWidth / 8,
   parameter int NumOutstanding = 4,
   parameter int CntWidth       = $clog2(NumOutstanding + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 we_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [StrbWidth-1:0] strb_i,
   output logic                 rvalid_o,
   input  logic                 rready_i,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [StrbWidth-1:0] mem_strb_o,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic [CntWidth-1:0]  outstanding_o,
   output logic                 err_o
);

   localparam int PtrWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
   localparam logic [CntWidth:0] MaxSlots = (CntWidth + 1)'(NumOutstanding);

   logic [CntWidth-1:0]  inflight_q, inflight_d;
   logic [CntWidth-1:0]  count_q, count_d;
   logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
   logic                 err_q, err_d;
   logic [DataWidth-1:0] fifo_q [NumOutstanding];
   logic [CntWidth:0]    used_s;
   logic                 credit_s, issue_s, capture_s, pop_s;

   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
      if (p == PtrWidth'(NumOutstanding - 1)) begin
         return '0;
      end else begin
         return p + PtrWidth'(1);
      end
   endfunction

   // Credit depends on registers only, keeping rready/rvalid out of the grant path.
   assign used_s    = {1'b0, inflight_q} + {1'b0, count_q};
   assign credit_s  = (used_s < MaxSlots);
   assign mem_req_o = req_i & credit_s & ~rst_i;
   assign gnt_o     = mem_gnt_i & mem_req_o;

   assign mem_addr_o  = addr_i;
   assign mem_we_o    = we_i;
   assign mem_wdata_o = wdata_i;
   assign mem_strb_o  = strb_i;

   assign issue_s   = gnt_o;
   assign capture_s = mem_rvalid_i & (inflight_q != '0);
   assign pop_s     = rvalid_o & rready_i;

   assign rvalid_o      = (count_q != '0);
   assign rdata_o       = fifo_q[rd_ptr_q];
   assign outstanding_o = used_s[CntWidth-1:0];
   assign err_o         = err_q;

   always_comb begin
      inflight_d = inflight_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      err_d      = err_q | (mem_rvalid_i & (inflight_q == '0));
      case ({issue_s, capture_s})
         2'b10:   inflight_d = inflight_q + CntWidth'(1);
         2'b01:   inflight_d = inflight_q - CntWidth'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({capture_s, pop_s})
         2'b10:   count_d = count_q + CntWidth'(1);
         2'b01:   count_d = count_q - CntWidth'(1);
         default: count_d = count_q;
      endcase
      if (capture_s) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Storage is cleared on reset so rdata_o reads zero afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NumOutstanding; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
         if (capture_s) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
         end
      end
   end

   mem_port_credit_buffer_chk #(
      .NumOutstanding(NumOutstanding),
      .CntWidth      (CntWidth)
   ) u_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .count_i  (count_q),
      .used_i   (used_s),
      .capture_i(capture_s)
   );

endmodule

// Occupancy invariants of the credit buffer.
module mem_port_credit_buffer_chk #(
   parameter int NumOutstanding = 4,
   parameter int CntWidth       = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CntWidth-1:0] count_i,
   input  logic [CntWidth:0]   used_i,
   input  logic                capture_i
);

   localparam logic [CntWidth:0] MaxSlots = (CntWidth + 1)'(NumOutstanding);

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      {1'b0, count_i} <= MaxSlots);
   a_used_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      used_i <= MaxSlots);
   a_no_write_full: assert property (@(posedge clk_i) disable iff (rst_i)
      capture_i |-> ({1'b0, count_i} < MaxSlots));

endmodule

// File: tb/tb_mem_port_credit_buffer.sv
// Directed bench: a two-slot instance driven from a vector table, and a four-slot
// instance for the simultaneous-event and reset-while-busy sequences.
module tb_mem_port_credit_buffer;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        rst4 = 1'b1;
   logic        req = 1'b0, we = 1'b0, mgnt = 1'b0, mrv = 1'b0, rready = 1'b0;
   logic [31:0] addr  = 32'h0;
   logic [15:0] wdata = 16'h0;
   logic [1:0]  strb  = 2'b00;
   logic [15:0] mrdata = 16'h0;

   logic        gnt2, rvalid2, mreq2, mwe2, err2;
   logic [15:0] rdata2, mwdata2;
   logic [31:0] maddr2;
   logic [1:0]  mstrb2, outst2;

   logic        gnt4, rvalid4, mreq4, mwe4, err4;
   logic [15:0] rdata4, mwdata4;
   logic [31:0] maddr4;
   logic [1:0]  mstrb4;
   logic [2:0]  outst4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_credit_buffer #(.AddrWidth(32), .DataWidth(16), .NumOutstanding(2)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid2), .rready_i(rready), .rdata_o(rdata2),
      .mem_req_o(mreq2), .mem_gnt_i(mgnt), .mem_addr_o(maddr2), .mem_we_o(mwe2),
      .mem_wdata_o(mwdata2), .mem_strb_o(mstrb2), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
      .outstanding_o(outst2), .err_o(err2));

   mem_port_credit_buffer #(.AddrWidth(32), .DataWidth(16), .NumOutstanding(4)) dut4 (
      .clk_i(clk), .rst_i(rst4), .req_i(req), .gnt_o(gnt4), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid4), .rready_i(rready), .rdata_o(rdata4),
      .mem_req_o(mreq4), .mem_gnt_i(mgnt), .mem_addr_o(maddr4), .mem_we_o(mwe4),
      .mem_wdata_o(mwdata4), .mem_strb_o(mstrb4), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
      .outstanding_o(outst4), .err_o(err4));

   typedef struct {
      logic        rst, req, we, mgnt, mrv;
      logic [15:0] mrdata;
      logic        rready;
      logic        e_gnt, e_mreq, e_rvalid, rd_chk;
      logic [15:0] e_rdata;
      logic [1:0]  e_outst;
      logic        e_err;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input int r, input int rq, input int w, input int g, input int rv,
                               input int rd, input int rr, input int eg, input int em,
                               input int ev, input int rc, input int ed, input int eo,
                               input int ee);
      vec_t v;
      v.rst = 1'(r);      v.req = 1'(rq);      v.we = 1'(w);        v.mgnt = 1'(g);
      v.mrv = 1'(rv);     v.mrdata = 16'(rd);  v.rready = 1'(rr);
      v.e_gnt = 1'(eg);   v.e_mreq = 1'(em);   v.e_rvalid = 1'(ev); v.rd_chk = 1'(rc);
      v.e_rdata = 16'(ed); v.e_outst = 2'(eo); v.e_err = 1'(ee);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req = 1'b0; we = 1'b0; mgnt = 1'b0; mrv = 1'b0; mrdata = 16'h0; rready = 1'b0;
   endtask

   initial begin
      //        rst req we gnt mrv data  rr  | gnt mreq rv chk rdata out err
      vecs[0]  = mk(1, 1, 0, 1, 0, 0,     0,   0, 0, 0, 1, 0,     0, 0);
      vecs[1]  = mk(0, 1, 0, 1, 0, 0,     0,   1, 1, 0, 1, 0,     0, 0);
      vecs[2]  = mk(0, 1, 0, 1, 1, 'hA,   0,   1, 1, 0, 0, 0,     1, 0);
      vecs[3]  = mk(0, 1, 0, 1, 1, 'hB,   0,   0, 0, 1, 1, 'hA,   2, 0);
      vecs[4]  = mk(0, 1, 0, 1, 0, 0,     0,   0, 0, 1, 1, 'hA,   2, 0);
      vecs[5]  = mk(0, 1, 0, 1, 0, 0,     1,   0, 0, 1, 1, 'hA,   2, 0);
      vecs[6]  = mk(0, 1, 0, 1, 0, 0,     0,   1, 1, 1, 1, 'hB,   1, 0);
      vecs[7]  = mk(0, 0, 0, 1, 1, 'hC,   1,   0, 0, 1, 1, 'hB,   2, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0,     1,   0, 0, 1, 1, 'hC,   1, 0);
      vecs[9]  = mk(0, 1, 1, 1, 0, 0,     1,   1, 1, 0, 0, 0,     0, 0);
      vecs[10] = mk(0, 1, 1, 0, 1, 1,     1,   0, 1, 0, 0, 0,     1, 0);
      vecs[11] = mk(0, 1, 1, 1, 0, 0,     1,   1, 1, 1, 1, 1,     1, 0);
      vecs[12] = mk(0, 1, 1, 0, 1, 2,     1,   0, 1, 0, 0, 0,     1, 0);
      vecs[13] = mk(0, 1, 1, 1, 0, 0,     1,   1, 1, 1, 1, 2,     1, 0);
      vecs[14] = mk(0, 0, 1, 0, 1, 3,     1,   0, 0, 0, 0, 0,     1, 0);
      vecs[15] = mk(0, 0, 0, 0, 0, 0,     1,   0, 0, 1, 1, 3,     1, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 0,     0,   0, 0, 0, 0, 0,     0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; req = vecs[i].req; we = vecs[i].we; mgnt = vecs[i].mgnt;
         mrv = vecs[i].mrv; mrdata = vecs[i].mrdata; rready = vecs[i].rready;
         addr = 32'h1000_0000 + 32'(i); wdata = 16'hBEEF ^ 16'(i); strb = 2'(i);
         #1;
         check($sformatf("v%0d.gnt", i), 32'(gnt2), 32'(vecs[i].e_gnt));
         check($sformatf("v%0d.mem_req", i), 32'(mreq2), 32'(vecs[i].e_mreq));
         check($sformatf("v%0d.rvalid", i), 32'(rvalid2), 32'(vecs[i].e_rvalid));
         if (vecs[i].rd_chk) begin
            check($sformatf("v%0d.rdata", i), 32'(rdata2), 32'(vecs[i].e_rdata));
         end
         check($sformatf("v%0d.outstanding", i), 32'(outst2), 32'(vecs[i].e_outst));
         check($sformatf("v%0d.err", i), 32'(err2), 32'(vecs[i].e_err));
         check($sformatf("v%0d.passthru", i),
               32'({(maddr2 == 32'h1000_0000 + 32'(i)), (mwe2 == vecs[i].we),
                    (mwdata2 == (16'hBEEF ^ 16'(i))), (mstrb2 == 2'(i))}), 32'hF);
         step();
      end

      // Spurious response with nothing in flight.
      idle_inputs();
      mrv = 1'b1; mrdata = 16'h0055;
      #1 check("spur.err_before", 32'(err2), 32'h0);
      step();
      mrv = 1'b0;
      #1;
      check("spur.err_set", 32'(err2), 32'h1);
      check("spur.no_rvalid", 32'(rvalid2), 32'h0);
      check("spur.outstanding", 32'(outst2), 32'h0);
      repeat (3) step();
      check("spur.err_sticky", 32'(err2), 32'h1);
      rst = 1'b1;
      step();
      check("spur.err_cleared", 32'(err2), 32'h0);

      // Four-slot instance: issue + capture + pop in one cycle.
      rst4 = 1'b0;
      req = 1'b1; mgnt = 1'b1;
      #1 check("sim.first_gnt", 32'(gnt4), 32'h1);
      step();
      mrv = 1'b1; mrdata = 16'h0011;
      #1 check("sim.second_gnt", 32'(gnt4), 32'h1);
      step();
      mrdata = 16'h0022; rready = 1'b1;
      #1;
      check("sim.gnt_same_cycle", 32'(gnt4), 32'h1);
      check("sim.head_before", 32'(rdata4), 32'h0011);
      check("sim.outst_before", 32'(outst4), 32'h2);
      step();
      idle_inputs();
      #1;
      check("sim.outst_after", 32'(outst4), 32'h2);
      check("sim.rvalid_after", 32'(rvalid4), 32'h1);
      check("sim.head_after", 32'(rdata4), 32'h0022);

      // Reset while busy, then a stale response.
      req = 1'b1; mgnt = 1'b1;
      step();
      check("rst.outst_busy", 32'(outst4), 32'h3);
      rst4 = 1'b1;
      #1 check("rst.req_gated", 32'({mreq4, gnt4}), 32'h0);
      step();
      rst4 = 1'b0; req = 1'b0;
      #1;
      check("rst.outputs_zero", 32'({gnt4, mreq4, rvalid4, err4}), 32'h0);
      check("rst.rdata_zero", 32'(rdata4), 32'h0);
      check("rst.outst_zero", 32'(outst4), 32'h0);
      mrv = 1'b1; mrdata = 16'h0033;
      step();
      mrv = 1'b0;
      #1;
      check("rst.stale_err", 32'(err4), 32'h1);
      check("rst.stale_no_rvalid", 32'({rvalid4, 1'b0, outst4}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_credit_buffer.md
Name: mem_port_credit_buffer

Overview:
- Per-port front-end placed directly upstream of each narrow or wide port of the geared memory island.
- The island returns `rvalid`/`rdata` with no backpressure. This block therefore issues a request only when a response-buffer slot is guaranteed, then buffers responses toward a master that may stall via `rready_i`.
- Instantiated once per narrow port and once per wide port, with `DataWidth` set accordingly.

Parameters:
- AddrWidth, 32, address width.
- DataWidth, 64, data width (narrow or wide).
- StrbWidth, DataWidth/8, derived, do not override.
- NumOutstanding, 4, response slots = max in-flight plus buffered responses; ≥1.
- CntWidth, $clog2(NumOutstanding+1), derived counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  upstream request valid.
- gnt_o  out  1  upstream grant.
- addr_i  in  AddrWidth  request address.
- we_i  in  1  write enable.
- wdata_i  in  DataWidth  write data.
- strb_i  in  StrbWidth  byte strobes.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response ready.
- rdata_o  out  DataWidth  response data.
- mem_req_o  out  1  request to memory island port.
- mem_gnt_i  in  1  island grant.
- mem_addr_o  out  AddrWidth  forwarded addr.
- mem_we_o  out  1  forwarded we.
- mem_wdata_o  out  DataWidth  forwarded wdata.
- mem_strb_o  out  StrbWidth  forwarded strb.
- mem_rvalid_i  in  1  island response valid, no backpressure.
- mem_rdata_i  in  DataWidth  island response data.
- outstanding_o  out  CntWidth  inflight_q + count_q.
- err_o  out  1  sticky spurious-response flag.

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.
- State: `inflight_q` (granted, response not yet returned), `count_q` (FIFO occupancy), FIFO of NumOutstanding×DataWidth, `wr_ptr`/`rd_ptr` wrapping modulo NumOutstanding, `err_q`.
- Reset: all counters, pointers and `err_q` go to 0.
  - Outputs under reset: `gnt_o`=0, `mem_req_o`=0, `rvalid_o`=0, `outstanding_o`=0, `err_o`=0, `rdata_o`=0.
  - The island is reset together with this block. Any response arriving after reset with `inflight_q`=0 is spurious.
- Credit: `credit = (inflight_q + count_q < NumOutstanding)`, computed from registers only.
  - No combinational path from `rready_i` or `mem_rvalid_i` to `gnt_o` or `mem_req_o`.
- Request path (combinational pass-through, zero latency):
  - `mem_req_o = req_i & credit & !rst_i`.
  - `gnt_o = mem_gnt_i & mem_req_o`.
  - `mem_addr_o`, `mem_we_o`, `mem_wdata_o`, `mem_strb_o` equal the `*_i` inputs unconditionally.
- Issue: `mem_req_o & mem_gnt_i` increments `inflight_q`. Reads and writes are treated identically; every granted request yields exactly one `mem_rvalid_i`, forwarded upstream with whatever data the island returns.
- Response capture: when `mem_rvalid_i` is high and `inflight_q` > 0:
  - write `mem_rdata_i` at `wr_ptr`;
  - `wr_ptr`+1;
  - `inflight_q`−1;
  - `count_q`+1.
- Spurious response: `mem_rvalid_i` with `inflight_q`=0 is dropped and sets `err_q`. `err_q` stays set until reset.
- Response output: `rvalid_o = (count_q != 0)`; `rdata_o` = FIFO[`rd_ptr`].
  - Latency from `mem_rvalid_i` to `rvalid_o` is 1 cycle minimum.
  - `rdata_o` must remain stable while `rvalid_o & !rready_i`.
- Pop: `rvalid_o & rready_i` advances `rd_ptr` and decrements `count_q`.
- Simultaneous events in one cycle:
  - Issue, capture and pop may all occur; each counter takes its net update (e.g. issue+capture leaves `inflight_q` unchanged).
  - Capture and pop with `count_q`=NumOutstanding cannot occur, since credit blocks over-issue.
- Credit release timing: a pop or capture in cycle N makes new credit visible in cycle N+1.
- Full: when `inflight_q + count_q == NumOutstanding`, `mem_req_o`=0 and `gnt_o`=0 even if `req_i`=1.
- Ordering: responses are delivered upstream in island return order, which is issue order per port.
- Assertions (simulation only):
  - `count_q` ≤ NumOutstanding;
  - `inflight_q + count_q` ≤ NumOutstanding;
  - no FIFO write when full.

Test Plan:
- NumOutstanding=2, `rready_i`=0, `req_i` held, `mem_gnt_i`=1, island returns each read 1 cycle later with data 0xA, 0xB → exactly 2 grants, then `gnt_o`=0. `rvalid_o`=1 with `rdata_o`=0xA stable; `outstanding_o`=2.
- Continue the previous case: raise `rready_i` for 1 cycle → 0xA popped, `rdata_o`=0xB. In the next cycle `gnt_o`=1 again, and not in the same cycle as the pop.
- `rready_i`=1, back-to-back requests, `mem_gnt_i` toggling 1,0,1 → `inflight_q` increments only on granted cycles. Writes (`we_i`=1) each yield one `rvalid_o`. Responses arrive in order 1,2,3.
- `mem_rvalid_i` pulse with `inflight_q`=0 → no FIFO write, `rvalid_o` stays 0, `err_o`=1 and remains 1 until `rst_i`.
- Same cycle: issue grant, island response and upstream pop with `inflight_q`=1, `count_q`=1 → next cycle `inflight_q`=1, `count_q`=1, and new data is at the head.
- Assert `rst_i` with `inflight_q`=2, `count_q`=1 → next cycle all outputs 0 and `outstanding_o`=0. A later stale `mem_rvalid_i` sets `err_o`.
